sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_responder_pkg.sv | 30 +++
 rtl/sram_like_responder_lfsr16.sv | 28 ++
 rtl/sram_like_responder.sv | 127 ++++++++++++
 tb/tb_sram_like_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_like_responder_pkg.sv
// Types and helpers shared by the SRAM-like responder and the initiators that drive it.
package sram_like_responder_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int unsigned TIMER_W = 4;

  typedef struct packed {
    logic                we;
    logic [31:0]         data;
    logic [TIMER_W-1:0]  timer;
  } entry_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_like_responder_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle; reset loads the seed.
module lfsr16 (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb_s;

  always_comb begin
    fb_s   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = {lfsr_q[14:0], fb_s};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like responder: single-cycle accept, fixed-latency in-order completion over a
// byte-writable backing store, with optional pseudo-random accept denial.
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        stall_en,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [15:0]      lfsr_s;
  logic             stall_now_s;
  logic             push_s;
  logic             pop_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      mem_rd_s;
  entry_t           head_s;
  logic             unused_ok;

  logic [31:0]      mem_q   [MEM_WORDS];
  entry_t           entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .seed   (LFSR_SEED),
    .out    (lfsr_s)
  );

  // Accept depends only on occupancy and the stall draw, never on a same-cycle completion.
  always_comb begin
    stall_now_s = stall_en && (lfsr_s[1:0] == 2'b00);
    addr_ok     = resetn && req && (count_q != CNT_W'(DEPTH)) && !stall_now_s;
    push_s      = addr_ok;
    idx_s       = addr[2 +: IDX_W];
    mem_rd_s    = mem_q[idx_s];
    head_s      = entry_q[head_q];
    data_ok     = valid_q[head_q] && (head_s.timer == TIMER_W'(1));
    pop_s       = data_ok;
    rdata       = (data_ok && !head_s.we) ? head_s.data : 32'h0;
  end

  always_comb begin
    head_d = pop_s  ? ptr_inc(head_q) : head_q;
    tail_d = push_s ? ptr_inc(tail_q) : tail_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Outstanding entries: timers run down together; pop clears the head, push fills the tail.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid_q[i] && (entry_q[i].timer > TIMER_W'(1))) begin
          entry_q[i].timer <= entry_q[i].timer - TIMER_W'(1);
        end
      end
      if (pop_s) begin
        valid_q[head_q] <= 1'b0;
      end
      if (push_s) begin
        valid_q[tail_q] <= 1'b1;
        entry_q[tail_q] <= '{we: we, data: mem_rd_s, timer: TIMER_W'(LATENCY)};
      end
    end
  end

  // Backing store has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (push_s && we) begin
      mem_q[idx_s] <= merge_bytes(mem_q[idx_s], wdata, wstrb);
    end
  end

  assign unused_ok = ^{size, addr[31:2+IDX_W], addr[1:0], lfsr_s[15:2]};

endmodule

// File: tb/tb_sram_like_responder.sv
// Randomized scoreboard bench for sram_like_responder, plus a small-queue instance
// (DEPTH=2, LATENCY=4) exercising occupancy saturation.
module tb_sram_like_responder;
  import sram_like_responder_pkg::*;

  localparam int LAT   = 2;
  localparam int DEP   = 4;
  localparam int MW    = 1024;
  localparam int LAT_B = 4;
  localparam int DEP_B = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic req = 1'b0, we = 1'b0, stall_en = 1'b0;
  logic [1:0] size = 2'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0] wstrb = 4'd0;
  logic addr_ok, data_ok;
  logic [31:0] rdata;

  logic b_req = 1'b0, b_we = 1'b0, b_stall_en = 1'b0;
  logic [1:0] b_size = 2'd0;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic [3:0] b_wstrb = 4'd0;
  logic b_addr_ok, b_data_ok;
  logic [31:0] b_rdata;

  typedef struct {
    int          due;
    bit          is_load;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [MW];
  logic [31:0] mem_b [MW];
  logic [31:0] bdat [4];
  logic [15:0] lfsr_m;
  int errors = 0, checks = 0;
  int cyc = 0, popped_at = -1;
  int n_acc = 0, n_dok = 0, n_drop = 0;

  sram_like_responder #(.MEM_WORDS(MW), .LATENCY(LAT), .DEPTH(DEP), .LFSR_SEED(SEED)) dut (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .stall_en(stall_en),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_responder #(.MEM_WORDS(MW), .LATENCY(LAT_B), .DEPTH(DEP_B), .LFSR_SEED(SEED)) dut_b (
    .clk(clk), .resetn(resetn), .req(b_req), .we(b_we), .size(b_size), .addr(b_addr),
    .wstrb(b_wstrb), .wdata(b_wdata), .stall_en(b_stall_en),
    .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference stall generator: 16-bit Fibonacci sequence, taps 16,14,13,11.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_m <= SEED;
    else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] apply_strb(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MW);
  endfunction

  function automatic logic expect_ok();
    int cnt;
    cnt = sb.size() + ((popped_at == cyc) ? 1 : 0);
    return resetn && req && (cnt != DEP) && !(stall_en && (lfsr_m[1:0] == 2'b00));
  endfunction

  // Monitor: pops the scoreboard whenever a completion is due and checks the DUT outputs.
  always @(negedge clk) begin
    #2;
    if (!resetn) begin
      chk("reset addr_ok", {31'd0, addr_ok}, 32'd0);
      chk("reset data_ok", {31'd0, data_ok}, 32'd0);
      chk("reset rdata", rdata, 32'd0);
    end else begin
      if (data_ok) n_dok++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("data_ok due", {31'd0, data_ok}, 32'd1);
        chk("rdata", rdata, sb[0].is_load ? sb[0].data : 32'd0);
        void'(sb.pop_front());
        popped_at = cyc;
      end else begin
        chk("data_ok idle", {31'd0, data_ok}, 32'd0);
        chk("rdata idle", rdata, 32'd0);
      end
    end
  end

  // Holds the request in the current cycle until accepted; records expectations on handshake.
  task automatic issue_hold(input logic w, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
    bit   done;
    exp_t e;
    done = 0;
    req = 1'b1; we = w; addr = a; wstrb = s; wdata = d;
    size = 2'($urandom_range(0, 3));
    for (int k = 0; k < 64 && !done; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      chk("addr_ok", {31'd0, addr_ok}, {31'd0, expect_ok()});
      if (addr_ok) begin
        e.due = cyc + LAT;
        e.is_load = !w;
        if (w) begin
          mem_m[widx(a)] = apply_strb(mem_m[widx(a)], d, s);
          e.data = 32'd0;
        end else begin
          e.data = mem_m[widx(a)];
        end
        sb.push_back(e);
        n_acc++;
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept timeout: addr %h never accepted", a);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    @(negedge clk);
    issue_hold(w, a, s, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req = 1'b0;
      #3;
      chk("addr_ok no req", {31'd0, addr_ok}, {31'd0, expect_ok()});
    end
  endtask

  // Small-queue instance: req held for 8 cycles, alternating store/load of the same word.
  task automatic run_b();
    exp_t qb[$];
    exp_t e;
    int   q_idx;
    int   cnt;
    q_idx = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 8) begin
        b_req   = 1'b1;
        b_we    = (q_idx % 2) == 0;
        b_addr  = 32'h100 + 32'((q_idx / 2) * 4);
        b_wstrb = 4'hF;
        b_wdata = bdat[q_idx % 4];
      end else begin
        b_req = 1'b0;
      end
      #3;
      cnt = qb.size();
      chk("b addr_ok", {31'd0, b_addr_ok}, {31'd0, b_req && (cnt != DEP_B)});
      if (cnt > 0 && qb[0].due == cyc) begin
        chk("b data_ok due", {31'd0, b_data_ok}, 32'd1);
        chk("b rdata", b_rdata, qb[0].is_load ? qb[0].data : 32'd0);
        void'(qb.pop_front());
      end else begin
        chk("b data_ok idle", {31'd0, b_data_ok}, 32'd0);
      end
      if (b_req && b_addr_ok) begin
        e.due = cyc + LAT_B;
        e.is_load = !b_we;
        if (b_we) begin
          mem_b[widx(b_addr)] = b_wdata;
          e.data = 32'd0;
        end else begin
          e.data = mem_b[widx(b_addr)];
        end
        qb.push_back(e);
        q_idx++;
      end
    end
    chk("b accepted count", 32'(q_idx), 32'd4);
    chk("b drained", 32'(qb.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) bdat[i] = $urandom;
    req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    resetn = 1'b1;
    run_b();

    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    idle(4);
    issue(1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(1'b1, 32'h21, 4'b0010, 32'h5A5A5A5A);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    idle(4);
    issue(1'b1, 32'h0000_1000, 4'hF, 32'hCAFEF00D);
    issue(1'b0, 32'h0000_0000, 4'h0, 32'h0);
    idle(4);

    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom);
    idle(4);

    stall_en = 1'b1;
    for (int n = 0; n < 100; n++) begin
      issue(1'($urandom_range(0, 1)),
            ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    stall_en = 1'b0;
    idle(8);

    issue(1'b1, 32'h40, 4'hF, 32'h0BADF00D);
    idle(4);
    issue(1'b0, 32'h44, 4'hF, 32'h0);
    issue(1'b1, 32'h44, 4'hF, 32'h600DCAFE);
    @(negedge clk);
    resetn = 1'b0;
    req = 1'b0;
    n_drop += sb.size();
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    issue_hold(1'b0, 32'h40, 4'h0, 32'h0);
    issue(1'b0, 32'h44, 4'h0, 32'h0);
    idle(6);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    chk("completion count", 32'(n_dok), 32'(n_acc - n_drop));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
